// File: rtl/fifo_reader_pkg.sv
// Shared types and defaults for the FIFO stream reader.
package fifo_reader_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// Small circular skid buffer that absorbs the FIFO's one-cycle read latency.
// DEPTH must be a power of two so the pointers wrap for free.
module fifo_rd_skid #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic [DATA_W-1:0]        dout
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [AW-1:0]                wr_ptr, rd_ptr;

  // Storage, pointers and occupancy; clear drops contents but keeps stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side engine: drains a synchronous FIFO onto a valid/ready stream.
// Optional feature: define READER_LAST_EN to generate m_last every BURST_LEN pops.
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SKID_DEPTH = 2,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int BURST_LEN  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              flush,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_r_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              flush_done,
  output logic [CNT_W-1:0]  beat_cnt
);

  localparam int SW = $clog2(SKID_DEPTH);

  rd_state_e     state, state_nxt;
  logic          inflight, pop, push, credit_ok;
  logic [SW:0]   skid_cnt;
  logic [SW+1:0] credit_use;

  // Words held plus the word on its way, less the one leaving now.
  assign credit_use = (SW+2)'(skid_cnt) + (SW+2)'(inflight) - (SW+2)'(pop);
  assign credit_ok  = credit_use < (SW+2)'(SKID_DEPTH);

  assign pop     = m_valid & m_ready;
  assign m_valid = (skid_cnt != '0) & !flush;
  // Returning data is only kept while streaming; during flush it is dropped.
  assign push    = inflight & (state == RUN) & !flush;
  assign busy    = (state != IDLE);

  fifo_rd_skid #(.DATA_W(DATA_W), .DEPTH(SKID_DEPTH)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .push (push),
    .din  (fifo_rdata),
    .pop  (pop),
    .cnt  (skid_cnt),
    .dout (m_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, read strobe and flush completion; flush overrides everything.
  always_comb begin
    state_nxt  = state;
    fifo_r_en  = 1'b0;
    flush_done = 1'b0;
    case (state)
      IDLE:  if (enable) state_nxt = RUN;
      RUN: begin
        fifo_r_en = enable & !fifo_empty & credit_ok;
        if (!enable && !inflight) state_nxt = IDLE;
      end
      FLUSH: begin
        fifo_r_en = !fifo_empty;
        if (fifo_empty && !inflight) begin
          state_nxt  = IDLE;
          flush_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt  = FLUSH;
      fifo_r_en  = !fifo_empty;
      flush_done = 1'b0;
    end
  end

  // Outstanding FIFO read and accepted-beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      beat_cnt <= '0;
    end else begin
      inflight <= fifo_r_en;
      if (pop) beat_cnt <= beat_cnt + 1'b1;
    end
  end

`ifdef READER_LAST_EN
  localparam int BW = $clog2(BURST_LEN + 1);

  logic [BW-1:0] burst_cnt;
  logic          burst_end;

  assign burst_end = (burst_cnt == BW'(BURST_LEN - 1));
  assign m_last    = m_valid & burst_end;

  // Position within the current burst; restarts on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        burst_cnt <= '0;
    else if (flush) burst_cnt <= '0;
    else if (pop)   burst_cnt <= burst_end ? '0 : burst_cnt + 1'b1;
  end
`else
  logic unused_burst;
  assign unused_burst = ^BURST_LEN;
  assign m_last       = 1'b0;
`endif

endmodule
